display_source_selector: RTL and testbench
==========================================

DISPLAY_SOURCE_SELECTOR -- requirements
Module: display_source_selector

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, is the number of consecutive stable synchronized cycles before the button level is accepted; legal range is 1 to 65535.
REQ-002 Parameter SCROLL_CYCLES, default 64, is the auto-scroll period in cycles; it is used only when AUTO_SCROLL_EN is defined; legal range is 2 to 2^32-1.
REQ-003 Port CLK, input, 1 bit: the single clock. All state updates on the rising edge.
REQ-004 Port RESET, input, 1 bit: synchronous, active-high reset.
REQ-005 Port BTN_NEXT, input, 1 bit: raw, asynchronous, bouncing push-button. High means pressed.
REQ-006 Port FREEZE, input, 1 bit: level input. High holds DISPLAY_VALUE.
REQ-007 Port PC_IN, input, 32 bits: current program counter (source 0).
REQ-008 Port INSTR_IN, input, 32 bits: current instruction (source 1).
REQ-009 Port ALU_IN, input, 32 bits: ALU result (source 2).
REQ-010 Port WB_DATA, input, 32 bits: register-writeback data (source 3).
REQ-011 Port WB_VALID, input, 1 bit: qualifies WB_DATA.
REQ-012 Port DISPLAY_VALUE, output, 32 bits: registered value fed to the seven-segment panel input.
REQ-013 Port SEL_INDEX, output, 2 bits: the currently selected source.

Function
REQ-014 BTN_NEXT shall pass through a 2-flop synchronizer before any other use.
REQ-015 The debouncer shall hold a stable level, initially 0, and a counter.
- Counter clears on any cycle where the synchronized input differs from the previous synchronized value.
- Otherwise the counter increments, saturating.
- When the count reaches DEBOUNCE_CYCLES, the stable level takes the synchronized value.
REQ-016 A 0->1 transition of the stable level shall generate one advance pulse, one cycle wide.
- The 1->0 transition generates none.
- Holding the button generates no further pulses.
REQ-017 Each advance pulse shall set SEL_INDEX to (SEL_INDEX+1) mod 4 on the following edge; 3 wraps to 0.
REQ-018 The writeback holding register shall capture WB_DATA on every edge where WB_VALID=1, and hold otherwise; this applies regardless of FREEZE.
REQ-019 With FREEZE=0, DISPLAY_VALUE shall load on each edge from the source selected by SEL_INDEX's current value:
- PC_IN, INSTR_IN or ALU_IN directly;
- for source 3, the holding register.
- This gives exactly one cycle of latency from input to output.
REQ-020 With FREEZE=1, DISPLAY_VALUE shall hold its value. SEL_INDEX still advances. The first edge with FREEZE=0 reloads the output from the current selection.
REQ-021 When source 3 is selected and WB_VALID=1 on the same edge, DISPLAY_VALUE shall show the previously held writeback value; the new value appears one cycle later.
REQ-022 No combinational path shall exist from any input to DISPLAY_VALUE or SEL_INDEX.

Reset
REQ-023 On RESET=1 at an edge, the following shall be cleared to 0:
- SEL_INDEX, DISPLAY_VALUE and the writeback holding register;
- the synchronizer flops, debounce counter, stable level and edge-detect flop;
- the scroll timer.
REQ-024 RESET shall take priority over all other inputs. A reset asserted mid-debounce or mid-scroll discards the partial count. No advance pulse is generated by the exit from reset.

Configuration
REQ-025 Macro AUTO_SCROLL_EN.
- When defined, a 32-bit scroll timer increments each cycle. When it reaches SCROLL_CYCLES-1 it returns to 0 and generates an advance pulse.
- A button advance pulse resets the timer to 0.
- A simultaneous timer pulse and button pulse advances SEL_INDEX by exactly 1.
- FREEZE=1 stalls the timer at its current value.
- When AUTO_SCROLL_EN is undefined, no timer logic exists and SEL_INDEX changes only on button pulses.

Verification
REQ-026 Reset, then apply PC_IN=0x00000040 and INSTR_IN=0x00A00093.
- Required: SEL_INDEX=0, and DISPLAY_VALUE=0x00000040 one cycle after the inputs settle.
REQ-027 With DEBOUNCE_CYCLES=4, toggle BTN_NEXT 1/0 every cycle for 10 cycles, then hold it at 1 for 10 cycles.
- Required: exactly one SEL_INDEX increment (0->1), occurring 2+4+1 cycles after the final rising edge.
REQ-028 Make four clean presses starting from SEL_INDEX=0.
- Required: SEL_INDEX goes 1,2,3,0, and DISPLAY_VALUE follows the matching sources.
REQ-029 Select source 3, pulse WB_VALID with WB_DATA=0xDEADBEEF, then WB_VALID=0 with WB_DATA=0x12345678.
- Required: DISPLAY_VALUE stays 0xDEADBEEF.
REQ-030 With FREEZE=1 and ALU selected, change ALU_IN from 0x5 to 0x9 and press the button.
- Required while frozen: DISPLAY_VALUE stays 0x5 and SEL_INDEX becomes 3.
- Required after release: on FREEZE=0, DISPLAY_VALUE takes the held writeback value.
REQ-031 Build with AUTO_SCROLL_EN defined and SCROLL_CYCLES=8, no button activity.
- Required: SEL_INDEX advances every 8 cycles.
- Required: a button pulse landing on the timer-wrap cycle causes a single increment.

Source files
------------

// File: rtl/display_source_selector.sv
// Debounced push-button cycles a registered 32-bit display value through four debug sources.
// Optional timed auto-scroll is built when AUTO_SCROLL_EN is defined.
module display_source_selector #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned SCROLL_CYCLES   = 64
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        BTN_NEXT,
    input  logic        FREEZE,
    input  logic [31:0] PC_IN,
    input  logic [31:0] INSTR_IN,
    input  logic [31:0] ALU_IN,
    input  logic [31:0] WB_DATA,
    input  logic        WB_VALID,
    output logic [31:0] DISPLAY_VALUE,
    output logic [1:0]  SEL_INDEX
);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be in 1..65535");
    end
    if (SCROLL_CYCLES < 2) begin : g_bad_scroll
        $error("SCROLL_CYCLES must be at least 2");
    end

    localparam logic [15:0] DEB_LIMIT = 16'(DEBOUNCE_CYCLES);

    logic        btn_meta;
    logic        btn_sync;
    logic        btn_prev;
    logic [15:0] deb_count;
    logic [15:0] deb_count_inc;
    logic        btn_stable;
    logic        btn_stable_q;
    logic        btn_pulse;
    logic        advance;
    logic [31:0] wb_hold;
    logic [31:0] source_value;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            btn_prev <= 1'b0;
        end else begin
            btn_meta <= BTN_NEXT;
            btn_sync <= btn_meta;
            btn_prev <= btn_sync;
        end
    end

    always_comb begin
        deb_count_inc = (deb_count == DEB_LIMIT) ? deb_count : deb_count + 16'd1;
    end

    // The stable level loads on the same edge the count reaches the limit.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            deb_count    <= '0;
            btn_stable   <= 1'b0;
            btn_stable_q <= 1'b0;
        end else begin
            if (btn_sync != btn_prev) begin
                deb_count <= '0;
            end else begin
                deb_count <= deb_count_inc;
                if (deb_count_inc == DEB_LIMIT) begin
                    btn_stable <= btn_sync;
                end
            end
            btn_stable_q <= btn_stable;
        end
    end

    always_comb begin
        btn_pulse = btn_stable & ~btn_stable_q;
    end

`ifdef AUTO_SCROLL_EN
    localparam logic [31:0] SCROLL_LAST = 32'(SCROLL_CYCLES - 1);

    logic [31:0] scroll_timer;
    logic        scroll_pulse;

    always_comb begin
        scroll_pulse = !FREEZE && (scroll_timer == SCROLL_LAST);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            scroll_timer <= '0;
        end else if (btn_pulse) begin
            scroll_timer <= '0;
        end else if (FREEZE) begin
            scroll_timer <= scroll_timer;
        end else if (scroll_pulse) begin
            scroll_timer <= '0;
        end else begin
            scroll_timer <= scroll_timer + 32'd1;
        end
    end

    // Coincident timer and button pulses merge into a single step.
    always_comb begin
        advance = btn_pulse | scroll_pulse;
    end
`else
    always_comb begin
        advance = btn_pulse;
    end
`endif

    always_comb begin
        case (SEL_INDEX)
            2'd0:    source_value = PC_IN;
            2'd1:    source_value = INSTR_IN;
            2'd2:    source_value = ALU_IN;
            default: source_value = wb_hold;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wb_hold       <= '0;
            SEL_INDEX     <= '0;
            DISPLAY_VALUE <= '0;
        end else begin
            if (WB_VALID) begin
                wb_hold <= WB_DATA;
            end
            if (advance) begin
                SEL_INDEX <= SEL_INDEX + 2'd1;
            end
            if (!FREEZE) begin
                DISPLAY_VALUE <= source_value;
            end
        end
    end

endmodule

// File: tb/tb_display_source_selector.sv
// Bench for display_source_selector: vector table, directed debounce/scroll sequences,
// and randomized stimulus checked every cycle against a rule-level reference model.
module tb_display_source_selector;

    localparam int unsigned DEB = 4;
    localparam int unsigned SCR = 8;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        BTN_NEXT = 1'b0;
    logic        FREEZE = 1'b0;
    logic [31:0] PC_IN = '0;
    logic [31:0] INSTR_IN = '0;
    logic [31:0] ALU_IN = '0;
    logic [31:0] WB_DATA = '0;
    logic        WB_VALID = 1'b0;
    logic [31:0] DISPLAY_VALUE;
    logic [1:0]  SEL_INDEX;

    int tests = 0;
    int fails = 0;

    display_source_selector #(
        .DEBOUNCE_CYCLES(DEB),
        .SCROLL_CYCLES(SCR)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .BTN_NEXT(BTN_NEXT),
        .FREEZE(FREEZE),
        .PC_IN(PC_IN),
        .INSTR_IN(INSTR_IN),
        .ALU_IN(ALU_IN),
        .WB_DATA(WB_DATA),
        .WB_VALID(WB_VALID),
        .DISPLAY_VALUE(DISPLAY_VALUE),
        .SEL_INDEX(SEL_INDEX)
    );

    always #5 CLK = ~CLK;

    // Reference model: raw button history, run length of the synchronized level,
    // accepted level, pending rise, selection, display and writeback hold.
    bit          samples[3];
    int          run_len = 0;
    bit          m_stable = 1'b0;
    bit          m_rise = 1'b0;
    int          m_sel = 0;
    logic [31:0] m_disp = '0;
    logic [31:0] m_wb = '0;
    int unsigned m_tmr = 0;
    bit          model_live = 1'b0;

    always @(posedge CLK) begin
        if (RESET) begin
            samples  = '{1'b0, 1'b0, 1'b0};
            run_len  = 0;
            m_stable = 1'b0;
            m_rise   = 1'b0;
            m_sel    = 0;
            m_disp   = '0;
            m_wb     = '0;
            m_tmr    = 0;
        end else begin
            bit synced;
            bit prev_synced;
            bit btn_adv;
            bit tmr_adv;
            btn_adv = m_rise;
            tmr_adv = 1'b0;
`ifdef AUTO_SCROLL_EN
            tmr_adv = !FREEZE && (m_tmr == SCR - 1);
            if (btn_adv) m_tmr = 0;
            else if (!FREEZE) m_tmr = (m_tmr == SCR - 1) ? 0 : m_tmr + 1;
`endif
            if (!FREEZE) begin
                case (m_sel)
                    0: m_disp = PC_IN;
                    1: m_disp = INSTR_IN;
                    2: m_disp = ALU_IN;
                    default: m_disp = m_wb;
                endcase
            end
            if (WB_VALID) m_wb = WB_DATA;
            if (btn_adv || tmr_adv) m_sel = (m_sel + 1) % 4;
            synced      = samples[1];
            prev_synced = samples[0];
            m_rise      = 1'b0;
            if (synced != prev_synced) begin
                run_len = 0;
            end else begin
                if (run_len < int'(DEB)) run_len = run_len + 1;
                if (run_len == int'(DEB)) begin
                    m_rise   = synced && !m_stable;
                    m_stable = synced;
                end
            end
            samples[0] = samples[1];
            samples[1] = samples[2];
            samples[2] = BTN_NEXT;
        end
        model_live = 1'b1;
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (model_live) begin
            check("model_sel", 32'(SEL_INDEX), 32'(m_sel));
            check("model_disp", DISPLAY_VALUE, m_disp);
        end
    end

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RESET    = 1'b1;
        BTN_NEXT = 1'b0;
        FREEZE   = 1'b0;
        WB_VALID = 1'b0;
        repeat (3) tick();
        RESET = 1'b0;
    endtask

    task automatic press();
        BTN_NEXT = 1'b1;
        repeat (DEB + 6) tick();
        BTN_NEXT = 1'b0;
        repeat (DEB + 6) tick();
    endtask

    typedef struct {
        int          np;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] alu;
        logic [31:0] wbd;
        logic        wbv;
        logic        frz;
        logic [1:0]  sel;
        logic [31:0] disp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int btn_left;
        btn_left = 0;

        vecs[0] = '{0, 32'h40,  32'h00A00093, 32'h5, 32'h0,        1'b0, 1'b0, 2'd0, 32'h40};
        vecs[1] = '{1, 32'h40,  32'h00A00093, 32'h5, 32'h0,        1'b0, 1'b0, 2'd1, 32'h00A00093};
        vecs[2] = '{1, 32'h40,  32'h00A00093, 32'h5, 32'h0,        1'b0, 1'b0, 2'd2, 32'h5};
        vecs[3] = '{0, 32'h40,  32'h00A00093, 32'h9, 32'hDEADBEEF, 1'b1, 1'b1, 2'd2, 32'h5};
        vecs[4] = '{1, 32'h40,  32'h00A00093, 32'h9, 32'h12345678, 1'b0, 1'b1, 2'd3, 32'h5};
        vecs[5] = '{0, 32'h40,  32'h00A00093, 32'h9, 32'h12345678, 1'b0, 1'b0, 2'd3, 32'hDEADBEEF};
        vecs[6] = '{0, 32'h40,  32'h00A00093, 32'h9, 32'h12345678, 1'b0, 1'b0, 2'd3, 32'hDEADBEEF};
        vecs[7] = '{0, 32'h40,  32'h00A00093, 32'h9, 32'hCAFEF00D, 1'b1, 1'b0, 2'd3, 32'hDEADBEEF};
        vecs[8] = '{0, 32'h40,  32'h00A00093, 32'h9, 32'h12345678, 1'b0, 1'b0, 2'd3, 32'hCAFEF00D};
        vecs[9] = '{1, 32'h100, 32'h00A00093, 32'h9, 32'h12345678, 1'b0, 1'b0, 2'd0, 32'h100};

        do_reset();
        check("reset_sel", 32'(SEL_INDEX), 32'd0);
        check("reset_disp", DISPLAY_VALUE, 32'd0);

`ifndef AUTO_SCROLL_EN
        for (int v = 0; v < 10; v++) begin
            PC_IN    = vecs[v].pc;
            INSTR_IN = vecs[v].instr;
            ALU_IN   = vecs[v].alu;
            WB_DATA  = vecs[v].wbd;
            WB_VALID = vecs[v].wbv;
            FREEZE   = vecs[v].frz;
            for (int p = 0; p < vecs[v].np; p++) press();
            tick();
            check($sformatf("vec%0d_sel", v), 32'(SEL_INDEX), 32'(vecs[v].sel));
            check($sformatf("vec%0d_disp", v), DISPLAY_VALUE, vecs[v].disp);
        end
`endif

        // Bouncing button, then a held press: one step, seven edges into the hold.
        do_reset();
        FREEZE = 1'b1;
        for (int i = 0; i < 10; i++) begin
            BTN_NEXT = (i % 2 == 0);
            tick();
            check("bounce_sel", 32'(SEL_INDEX), 32'd0);
        end
        BTN_NEXT = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("hold_sel_k%0d", k), 32'(SEL_INDEX), (k >= 7) ? 32'd1 : 32'd0);
        end
        BTN_NEXT = 1'b0;
        repeat (DEB + 8) tick();
        FREEZE = 1'b0;

`ifdef AUTO_SCROLL_EN
        do_reset();
        for (int i = 0; i < 32; i++) begin
            tick();
            check($sformatf("scroll_i%0d", i), 32'(SEL_INDEX), 32'(((i + 1) / 8) % 4));
        end
        // Button pulse lands on the same edge as the first timer wrap.
        do_reset();
        BTN_NEXT = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check($sformatf("collide_i%0d", i), 32'(SEL_INDEX), 32'((i + 1) / 8));
        end
        BTN_NEXT = 1'b0;
`endif

        do_reset();
        for (int c = 0; c < 1500; c++) begin
            RESET = ($urandom_range(0, 299) == 0);
            if (btn_left == 0) begin
                BTN_NEXT = 1'($urandom_range(0, 1));
                btn_left = int'($urandom_range(1, 12));
            end
            btn_left--;
            FREEZE   = ($urandom_range(0, 7) == 0);
            PC_IN    = $urandom;
            INSTR_IN = $urandom;
            ALU_IN   = $urandom;
            WB_DATA  = $urandom;
            WB_VALID = 1'($urandom_range(0, 1));
            tick();
        end
        RESET = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
